// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and anode decode for the seven-segment scan driver.
package seg_pkg;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;

    localparam logic [4:0]       CODE_BLANK = 5'd16;
    localparam logic [4:0]       CODE_DASH  = 5'd17;
    localparam logic [BIN_W-1:0] MAX_VALUE  = 14'd9999;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StCommit
    } state_e;

    // Active-low one-cold anode pattern for a digit slot.
    function automatic logic [3:0] an_decode(input logic [1:0] sel);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle, BIN_W cycles total.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [BIN_W-1:0] sreg_q, sreg_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]       iter_q, iter_d;
    logic             run_q, run_d;

    // done is high in the cycle whose closing edge performs the final iteration,
    // so bcd holds the result right after that edge.
    assign done = run_q && (iter_q == 4'd1);
    assign bcd  = bcd_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end

        sreg_d = sreg_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        run_d  = run_q;
        if (start) begin
            sreg_d = bin;
            bcd_d  = '0;
            iter_d = 4'(BIN_W);
            run_d  = 1'b1;
        end else if (run_q) begin
            bcd_d  = {bcd_adj[BCD_W-2:0], sreg_q[BIN_W-1]};
            sreg_d = {sreg_q[BIN_W-2:0], 1'b0};
            iter_d = iter_q - 4'd1;
            run_d  = (iter_q != 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_q <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: converts a binary value to BCD on request
// and scans the committed digits across the active-low anodes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] value,
    input  logic             load,
    input  logic             lz_blank,
    output logic [3:0]       an,
    output logic [4:0]       digit_holder,
    output logic             busy
);

    state_e                  state_q, state_d;
    logic                    busy_q;
    logic                    lz_q, ovf_q;
    logic [3:0][4:0]         digits_q, digits_d;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [3:0]              an_q;
    logic [4:0]              dh_q;
    logic [1:0]              sel;
    logic                    start, commit;
    logic                    conv_done;
    logic [BCD_W-1:0]        bcd;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (value),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign sel          = refresh_q[REFRESH_BITS-1 -: 2];
    assign an           = an_q;
    assign digit_holder = dh_q;
    assign busy         = busy_q;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    start   = 1'b1;
                    state_d = StConv;
                end
            end
            StConv: begin
                if (conv_done) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Blanking cascades from the thousands digit down; the ones digit always shows.
    always_comb begin
        digits_d = digits_q;
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                digits_d[i] = {1'b0, bcd[i*4 +: 4]};
            end
            if (ovf_q) begin
                digits_d = {4{CODE_DASH}};
            end else if (lz_q) begin
                if (bcd[15:12] == 4'd0) begin
                    digits_d[3] = CODE_BLANK;
                    if (bcd[11:8] == 4'd0) begin
                        digits_d[2] = CODE_BLANK;
                        if (bcd[7:4] == 4'd0) begin
                            digits_d[1] = CODE_BLANK;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            lz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            digits_q  <= {4{CODE_BLANK}};
            refresh_q <= '0;
            an_q      <= 4'b1111;
            dh_q      <= CODE_BLANK;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != StIdle);
            digits_q  <= digits_d;
            refresh_q <= refresh_q + 1'b1;
            an_q      <= an_decode(sel);
            dh_q      <= digits_q[sel];
            if (start) begin
                lz_q  <= lz_blank;
                ovf_q <= (value > MAX_VALUE);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with a 4-bit refresh counter.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        lz_blank;
    logic [3:0]  an;
    logic [4:0]  digit_holder;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference scan model: registered anode/slot derived from a free-running 4-bit counter.
    logic [3:0] m_cnt;
    logic [1:0] m_sel;
    logic [3:0] m_an;

    seg_scan_driver #(
        .REFRESH_BITS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value        (value),
        .load         (load),
        .lz_blank     (lz_blank),
        .an           (an),
        .digit_holder (digit_holder),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt <= 4'd0;
            m_sel <= 2'd0;
            m_an  <= 4'b1111;
        end else begin
            m_cnt <= m_cnt + 4'd1;
            m_sel <= m_cnt[3:2];
            m_an  <= ~(4'b0001 << m_cnt[3:2]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pack(input int d3, input int d2, input int d1, input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    // Returns just after the edge that samples load.
    task automatic start_load(input int v, input logic lz);
        value    = 14'(v);
        lz_blank = lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic finish_conv(input int from);
        for (int i = from; i < 15; i++) begin
            chk("busy_conv", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_display(input logic [19:0] exp);
        for (int i = 0; i < 16; i++) begin
            chk("an_scan", 32'(an), 32'(m_an));
            chk("digit", 32'(digit_holder), 32'(exp[int'(m_sel)*5 +: 5]));
            @(negedge clk);
        end
    endtask

    task automatic run_case(input int v, input logic lz, input logic [19:0] exp);
        start_load(v, lz);
        finish_conv(0);
        check_display(exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = '0;
        lz_blank = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_digit", 32'(digit_holder), 32'd16);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        check_display(pack(16, 16, 16, 16));

        run_case(1234, 1'b0, pack(1, 2, 3, 4));
        run_case(7, 1'b1, pack(16, 16, 16, 7));
        run_case(7, 1'b0, pack(0, 0, 0, 7));
        run_case(0, 1'b1, pack(16, 16, 16, 0));
        run_case(205, 1'b1, pack(16, 2, 0, 5));
        run_case(10000, 1'b1, pack(17, 17, 17, 17));
        run_case(9999, 1'b0, pack(9, 9, 9, 9));
        run_case(16383, 1'b0, pack(17, 17, 17, 17));

        // Second load during conversion must be dropped.
        start_load(1234, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_conv", 32'(busy), 32'd1);
            @(negedge clk);
        end
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        finish_conv(5);
        check_display(pack(1, 2, 3, 4));
        chk("no_requeue", 32'(busy), 32'd0);
        check_display(pack(1, 2, 3, 4));

        // Reset in the middle of a conversion aborts it.
        start_load(4321, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_an", 32'(an), 32'hF);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_digit", 32'(digit_holder), 32'd16);
        rst_n = 1'b1;
        @(negedge clk);
        check_display(pack(16, 16, 16, 16));
        chk("abort_idle", 32'(busy), 32'd0);
        check_display(pack(16, 16, 16, 16));

        // Free-run: four full counter wraps with exactly one anode active.
        for (int i = 0; i < 64; i++) begin
            chk("one_cold", 32'($countones(~an)), 32'd1);
            chk("an_wrap", 32'(an), 32'(m_an));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
